// File: rtl/wb_retire_buffer.sv
// wb_retire_buffer: writeback retire FIFO between MEM/WB and the RegFile/HILO
// write ports. Accepted instructions are queued in a DEPTH-entry circular FIFO
// and drained one per cycle through registered single-cycle write pulses. The
// drain stalls while port_busy is high. A combinational lookup returns the
// youngest queued GPR value for fwd_addr.
//
// Optional feature: define WB_HILO_EN to store and drive HI/LO writes. Without
// it, HI/LO inputs are ignored and the HILO outputs are tied to 0.
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   in_valid/in_ready        retiring-instruction handshake
//   in_result/in_reg_en/in_reg_addr   GPR write request
//   in_hilo_en/in_hi/in_lo   HI/LO write request
//   flush                    synchronous discard of all queued entries
//   port_busy                RegFile port lent elsewhere; no drain this cycle
//   reg_we/reg_waddr/reg_wdata   registered RegFile write
//   hilo_we/hi_wdata/lo_wdata    registered HILO write
//   fwd_addr/fwd_hit/fwd_data    forwarding lookup (combinational)
//   count                    number of occupied entries
module wb_retire_buffer #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned DEPTH  = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [DATA_W-1:0]            in_result,
    input  logic                         in_reg_en,
    input  logic [ADDR_W-1:0]            in_reg_addr,
    input  logic                         in_hilo_en,
    input  logic [DATA_W-1:0]            in_hi,
    input  logic [DATA_W-1:0]            in_lo,
    input  logic                         flush,
    input  logic                         port_busy,
    output logic                         reg_we,
    output logic [ADDR_W-1:0]            reg_waddr,
    output logic [DATA_W-1:0]            reg_wdata,
    output logic                         hilo_we,
    output logic [DATA_W-1:0]            hi_wdata,
    output logic [DATA_W-1:0]            lo_wdata,
    input  logic [ADDR_W-1:0]            fwd_addr,
    output logic                         fwd_hit,
    output logic [DATA_W-1:0]            fwd_data,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH+1);

    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;

    logic              reg_we_q, reg_we_d;
    logic [ADDR_W-1:0] reg_waddr_q, reg_waddr_d;
    logic [DATA_W-1:0] reg_wdata_q, reg_wdata_d;

    // FIFO storage; contents are qualified by count, so no reset is needed
    logic              ent_reg_en_q [DEPTH];
    logic [ADDR_W-1:0] ent_addr_q   [DEPTH];
    logic [DATA_W-1:0] ent_data_q   [DEPTH];

    logic norm_reg_en;
    logic norm_hilo_en;
    logic push;
    logic pop;

    // Writes to r0 are architecturally void, so they never occupy an entry
    assign norm_reg_en = in_reg_en && (in_reg_addr != '0);

`ifdef WB_HILO_EN
    logic              hilo_we_q, hilo_we_d;
    logic [DATA_W-1:0] hi_wdata_q, hi_wdata_d;
    logic [DATA_W-1:0] lo_wdata_q, lo_wdata_d;
    logic              ent_hilo_en_q [DEPTH];
    logic [DATA_W-1:0] ent_hi_q      [DEPTH];
    logic [DATA_W-1:0] ent_lo_q      [DEPTH];

    assign norm_hilo_en = in_hilo_en;
    assign hilo_we      = hilo_we_q;
    assign hi_wdata     = hi_wdata_q;
    assign lo_wdata     = lo_wdata_q;
`else
    logic unused_hilo;

    assign unused_hilo  = &{1'b0, in_hilo_en, in_hi, in_lo};
    assign norm_hilo_en = 1'b0;
    assign hilo_we      = 1'b0;
    assign hi_wdata     = '0;
    assign lo_wdata     = '0;
`endif

    // Ready depends only on registered occupancy and reset
    assign in_ready = (count_q < CNT_W'(DEPTH)) && !rst;
    assign push     = in_valid && in_ready && (norm_reg_en || norm_hilo_en);
    assign pop      = (count_q != '0) && !port_busy;

    assign reg_we    = reg_we_q;
    assign reg_waddr = reg_waddr_q;
    assign reg_wdata = reg_wdata_q;
    assign count     = count_q;

    // Next-state: pointers, occupancy and the write-pulse output registers
    always_comb begin
        rd_ptr_d    = rd_ptr_q;
        wr_ptr_d    = wr_ptr_q;
        count_d     = count_q;
        reg_we_d    = 1'b0;
        reg_waddr_d = '0;
        reg_wdata_d = '0;
`ifdef WB_HILO_EN
        hilo_we_d   = 1'b0;
        hi_wdata_d  = '0;
        lo_wdata_d  = '0;
`endif
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_d    = rd_ptr_q + PTR_W'(1);
                reg_we_d    = ent_reg_en_q[rd_ptr_q];
                reg_waddr_d = ent_addr_q[rd_ptr_q];
                reg_wdata_d = ent_data_q[rd_ptr_q];
`ifdef WB_HILO_EN
                hilo_we_d   = ent_hilo_en_q[rd_ptr_q];
                hi_wdata_d  = ent_hi_q[rd_ptr_q];
                lo_wdata_d  = ent_lo_q[rd_ptr_q];
`endif
            end
            if (push && !pop) begin
                count_d = count_q + CNT_W'(1);
            end else if (pop && !push) begin
                count_d = count_q - CNT_W'(1);
            end
        end
    end

    // State and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            count_q     <= '0;
            reg_we_q    <= 1'b0;
            reg_waddr_q <= '0;
            reg_wdata_q <= '0;
`ifdef WB_HILO_EN
            hilo_we_q   <= 1'b0;
            hi_wdata_q  <= '0;
            lo_wdata_q  <= '0;
`endif
        end else begin
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            count_q     <= count_d;
            reg_we_q    <= reg_we_d;
            reg_waddr_q <= reg_waddr_d;
            reg_wdata_q <= reg_wdata_d;
`ifdef WB_HILO_EN
            hilo_we_q   <= hilo_we_d;
            hi_wdata_q  <= hi_wdata_d;
            lo_wdata_q  <= lo_wdata_d;
`endif
        end
    end

    // Entry write at the tail; a flush cycle drops the incoming entry
    always_ff @(posedge clk) begin
        if (push && !flush) begin
            ent_reg_en_q[wr_ptr_q]  <= norm_reg_en;
            ent_addr_q[wr_ptr_q]    <= in_reg_addr;
            ent_data_q[wr_ptr_q]    <= in_result;
`ifdef WB_HILO_EN
            ent_hilo_en_q[wr_ptr_q] <= in_hilo_en;
            ent_hi_q[wr_ptr_q]      <= in_hi;
            ent_lo_q[wr_ptr_q]      <= in_lo;
`endif
        end
    end

    // Forwarding: scan oldest to youngest so the youngest match wins
    always_comb begin
        logic [PTR_W-1:0] idx;
        fwd_hit  = 1'b0;
        fwd_data = '0;
        idx      = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            idx = rd_ptr_q + PTR_W'(i);
            if ((CNT_W'(i) < count_q) && ent_reg_en_q[idx] &&
                (ent_addr_q[idx] == fwd_addr) && (fwd_addr != '0)) begin
                fwd_hit  = 1'b1;
                fwd_data = ent_data_q[idx];
            end
        end
    end

endmodule

// File: tb/tb_wb_retire_buffer.sv
// Directed table-driven bench for wb_retire_buffer (DEPTH=4, default widths).
// Each row drives inputs for one clock and lists the outputs expected just
// after that clock's rising edge.
module tb_wb_retire_buffer;

`ifdef WB_HILO_EN
    localparam bit HILO = 1'b1;
`else
    localparam bit HILO = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0, in_ready;
    logic [31:0] in_result = '0;
    logic        in_reg_en = 1'b0;
    logic [4:0]  in_reg_addr = '0;
    logic        in_hilo_en = 1'b0;
    logic [31:0] in_hi = '0, in_lo = '0;
    logic        flush = 1'b0, port_busy = 1'b0;
    logic        reg_we, hilo_we, fwd_hit;
    logic [4:0]  reg_waddr;
    logic [4:0]  fwd_addr = '0;
    logic [31:0] reg_wdata, hi_wdata, lo_wdata, fwd_data;
    logic [2:0]  count;

    int checks = 0;
    int errors = 0;

    wb_retire_buffer #(.DATA_W(32), .ADDR_W(5), .DEPTH(4)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_result(in_result), .in_reg_en(in_reg_en), .in_reg_addr(in_reg_addr),
        .in_hilo_en(in_hilo_en), .in_hi(in_hi), .in_lo(in_lo),
        .flush(flush), .port_busy(port_busy),
        .reg_we(reg_we), .reg_waddr(reg_waddr), .reg_wdata(reg_wdata),
        .hilo_we(hilo_we), .hi_wdata(hi_wdata), .lo_wdata(lo_wdata),
        .fwd_addr(fwd_addr), .fwd_hit(fwd_hit), .fwd_data(fwd_data),
        .count(count)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          v, en, he, pb, fl;
        logic [4:0]  a, fa;
        logic [31:0] d, hi, lo;
        bit          e_we, e_hwe, e_rdy, e_hit;
        logic [4:0]  e_wa;
        logic [31:0] e_wd, e_hi, e_lo, e_fd;
        logic [2:0]  e_cnt;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t row(bit v, bit en, logic [4:0] a, logic [31:0] d,
                                 bit pb, bit fl, logic [4:0] fa,
                                 bit we, logic [4:0] wa, logic [31:0] wd,
                                 logic [2:0] cnt, bit rdy, bit hit, logic [31:0] fd);
        vec_t r;
        r.v = v; r.en = en; r.a = a; r.d = d; r.pb = pb; r.fl = fl; r.fa = fa;
        r.he = 1'b0; r.hi = '0; r.lo = '0;
        r.e_we = we; r.e_wa = wa; r.e_wd = wd; r.e_cnt = cnt; r.e_rdy = rdy;
        r.e_hit = hit; r.e_fd = fd;
        r.e_hwe = 1'b0; r.e_hi = '0; r.e_lo = '0;
        return r;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic check_row(input int n, input vec_t r);
        chk($sformatf("row%0d reg_we", n),    32'(reg_we),    32'(r.e_we));
        chk($sformatf("row%0d reg_waddr", n), 32'(reg_waddr), 32'(r.e_wa));
        chk($sformatf("row%0d reg_wdata", n), reg_wdata,      r.e_wd);
        chk($sformatf("row%0d hilo_we", n),   32'(hilo_we),   32'(r.e_hwe));
        chk($sformatf("row%0d hi_wdata", n),  hi_wdata,       r.e_hi);
        chk($sformatf("row%0d lo_wdata", n),  lo_wdata,       r.e_lo);
        chk($sformatf("row%0d count", n),     32'(count),     32'(r.e_cnt));
        chk($sformatf("row%0d in_ready", n),  32'(in_ready),  32'(r.e_rdy));
        chk($sformatf("row%0d fwd_hit", n),   32'(fwd_hit),   32'(r.e_hit));
        chk($sformatf("row%0d fwd_data", n),  fwd_data,       r.e_fd);
    endtask

    task automatic drive(input bit v, input bit en, input logic [4:0] a,
                         input logic [31:0] d, input bit pb, input logic [4:0] fa);
        in_valid = v; in_reg_en = en; in_reg_addr = a; in_result = d;
        in_hilo_en = 1'b0; in_hi = '0; in_lo = '0;
        port_busy = pb; flush = 1'b0; fwd_addr = fa;
    endtask

    initial begin
        vec_t r;
        //          v  en  a      d             pb fl fa    we wa     wd            cnt rdy hit fd
        // single write: 2-cycle latency, 1-cycle pulse
        vecs.push_back(row(1, 1, 5'd3, 32'hDEADBEEF, 0, 0, 5'd3, 0, 5'd0, 32'h0,        3'd1, 1, 1, 32'hDEADBEEF));
        vecs.push_back(row(0, 0, 5'd0, 32'h0,        0, 0, 5'd3, 1, 5'd3, 32'hDEADBEEF, 3'd0, 1, 0, 32'h0));
        vecs.push_back(row(0, 0, 5'd0, 32'h0,        0, 0, 5'd3, 0, 5'd0, 32'h0,        3'd0, 1, 0, 32'h0));
        // backpressure: fill to DEPTH, fifth is refused, then drain in order
        vecs.push_back(row(1, 1, 5'd1, 32'h101, 1, 0, 5'd1, 0, 5'd0, 32'h0,   3'd1, 1, 1, 32'h101));
        vecs.push_back(row(1, 1, 5'd2, 32'h202, 1, 0, 5'd1, 0, 5'd0, 32'h0,   3'd2, 1, 1, 32'h101));
        vecs.push_back(row(1, 1, 5'd3, 32'h303, 1, 0, 5'd1, 0, 5'd0, 32'h0,   3'd3, 1, 1, 32'h101));
        vecs.push_back(row(1, 1, 5'd4, 32'h404, 1, 0, 5'd1, 0, 5'd0, 32'h0,   3'd4, 0, 1, 32'h101));
        vecs.push_back(row(1, 1, 5'd5, 32'h505, 1, 0, 5'd5, 0, 5'd0, 32'h0,   3'd4, 0, 0, 32'h0));
        vecs.push_back(row(0, 0, 5'd0, 32'h0,   0, 0, 5'd4, 1, 5'd1, 32'h101, 3'd3, 1, 1, 32'h404));
        vecs.push_back(row(0, 0, 5'd0, 32'h0,   0, 0, 5'd4, 1, 5'd2, 32'h202, 3'd2, 1, 1, 32'h404));
        vecs.push_back(row(0, 0, 5'd0, 32'h0,   0, 0, 5'd4, 1, 5'd3, 32'h303, 3'd1, 1, 1, 32'h404));
        vecs.push_back(row(0, 0, 5'd0, 32'h0,   0, 0, 5'd4, 1, 5'd4, 32'h404, 3'd0, 1, 0, 32'h0));
        vecs.push_back(row(0, 0, 5'd0, 32'h0,   0, 0, 5'd4, 0, 5'd0, 32'h0,   3'd0, 1, 0, 32'h0));
        // simultaneous push and pop keeps count
        vecs.push_back(row(1, 1, 5'd6, 32'h66, 0, 0, 5'd0, 0, 5'd0, 32'h0,  3'd1, 1, 0, 32'h0));
        vecs.push_back(row(1, 1, 5'd7, 32'h77, 0, 0, 5'd0, 1, 5'd6, 32'h66, 3'd1, 1, 0, 32'h0));
        vecs.push_back(row(0, 0, 5'd0, 32'h0,  0, 0, 5'd0, 1, 5'd7, 32'h77, 3'd0, 1, 0, 32'h0));
        // forwarding picks the youngest match; address 0 never hits
        vecs.push_back(row(1, 1, 5'd7, 32'h11, 1, 0, 5'd7, 0, 5'd0, 32'h0, 3'd1, 1, 1, 32'h11));
        vecs.push_back(row(1, 1, 5'd7, 32'h22, 1, 0, 5'd7, 0, 5'd0, 32'h0, 3'd2, 1, 1, 32'h22));
        vecs.push_back(row(0, 0, 5'd0, 32'h0,  1, 0, 5'd0, 0, 5'd0, 32'h0, 3'd2, 1, 0, 32'h0));
        vecs.push_back(row(1, 1, 5'd9, 32'h99, 1, 0, 5'd7, 0, 5'd0, 32'h0, 3'd3, 1, 1, 32'h22));
        // flush with a valid input: everything dropped, no write pulse
        vecs.push_back(row(1, 1, 5'd10, 32'hAA, 0, 1, 5'd7, 0, 5'd0, 32'h0, 3'd0, 1, 0, 32'h0));
        vecs.push_back(row(0, 0, 5'd0,  32'h0,  0, 0, 5'd7, 0, 5'd0, 32'h0, 3'd0, 1, 0, 32'h0));
        // filtering: r0 write and no-enable transfer are not queued
        vecs.push_back(row(1, 1, 5'd0, 32'h55, 0, 0, 5'd0, 0, 5'd0, 32'h0, 3'd0, 1, 0, 32'h0));
        vecs.push_back(row(0, 0, 5'd0, 32'h0,  0, 0, 5'd0, 0, 5'd0, 32'h0, 3'd0, 1, 0, 32'h0));
        vecs.push_back(row(1, 0, 5'd5, 32'h5,  0, 0, 5'd5, 0, 5'd0, 32'h0, 3'd0, 1, 0, 32'h0));
        // HILO-only transfer: queued and written only when the feature is built
        r = row(1, 0, 5'd0, 32'h0, 0, 0, 5'd0, 0, 5'd0, 32'h0, 3'(HILO), 1, 0, 32'h0);
        r.he = 1'b1; r.hi = 32'h1; r.lo = 32'h2;
        vecs.push_back(r);
        r = row(0, 0, 5'd0, 32'h0, 0, 0, 5'd0, 0, 5'd0, 32'h0, 3'd0, 1, 0, 32'h0);
        r.e_hwe = HILO; r.e_hi = HILO ? 32'h1 : 32'h0; r.e_lo = HILO ? 32'h2 : 32'h0;
        vecs.push_back(r);
        vecs.push_back(row(0, 0, 5'd0, 32'h0, 0, 0, 5'd0, 0, 5'd0, 32'h0, 3'd0, 1, 0, 32'h0));

        // reset state
        #1 rst = 1'b1;
        #1;
        chk("rst in_ready", 32'(in_ready), 32'd0);
        chk("rst count",    32'(count),    32'd0);
        chk("rst reg_we",   32'(reg_we),   32'd0);
        chk("rst hilo_we",  32'(hilo_we),  32'd0);
        chk("rst fwd_hit",  32'(fwd_hit),  32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b0;
        #1 chk("post-rst in_ready", 32'(in_ready), 32'd1);

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            in_valid = vecs[i].v; in_reg_en = vecs[i].en; in_reg_addr = vecs[i].a;
            in_result = vecs[i].d; in_hilo_en = vecs[i].he; in_hi = vecs[i].hi;
            in_lo = vecs[i].lo; port_busy = vecs[i].pb; flush = vecs[i].fl;
            fwd_addr = vecs[i].fa;
            @(posedge clk);
            #1 check_row(i, vecs[i]);
        end

        // async reset mid-cycle with two entries queued and a write in flight
        @(negedge clk) drive(1, 1, 5'd11, 32'hB1, 1, 5'd13);
        @(negedge clk) drive(1, 1, 5'd12, 32'hB2, 1, 5'd13);
        @(negedge clk) drive(1, 1, 5'd13, 32'hB3, 1, 5'd13);
        @(negedge clk) drive(0, 0, 5'd0, 32'h0, 0, 5'd13);
        @(posedge clk);
        #1;
        chk("pre-arst reg_we",    32'(reg_we),    32'd1);
        chk("pre-arst reg_waddr", 32'(reg_waddr), 32'd11);
        chk("pre-arst count",     32'(count),     32'd2);
        chk("pre-arst fwd_data",  fwd_data,       32'hB3);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("arst reg_we",    32'(reg_we),    32'd0);
        chk("arst reg_waddr", 32'(reg_waddr), 32'd0);
        chk("arst reg_wdata", reg_wdata,      32'd0);
        chk("arst count",     32'(count),     32'd0);
        chk("arst in_ready",  32'(in_ready),  32'd0);
        chk("arst fwd_hit",   32'(fwd_hit),   32'd0);
        @(negedge clk) rst = 1'b0;
        @(posedge clk);
        #1;
        chk("after arst in_ready", 32'(in_ready), 32'd1);
        chk("after arst count",    32'(count),    32'd0);
        chk("after arst reg_we",   32'(reg_we),   32'd0);
        chk("after arst fwd_hit",  32'(fwd_hit),  32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
